// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: multi-precision add/subtract controller.
// A single WIDTH-bit group carry-lookahead adder is reused once per word,
// LS word first, with the inter-word carry held in a register.
// Optional: define MULTIWORD_ADD_OVF_EN to add the signed-overflow output ovf_o.

// 4-bit lookahead slice: internal carries plus group generate/propagate
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g, p, c;

    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign s  = p ^ c;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;
endmodule

// WIDTH-bit adder built from 4-bit lookahead groups; group carries chain on G/P
module Group_carry_lookahead_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);
    localparam int NG = WIDTH / 4;

    logic [NG:0]   gc;
    logic [NG-1:0] gg, pg;

    assign gc[0] = C_in;

    genvar i;
    generate
        for (i = 0; i < NG; i++) begin : g_grp
            cla4_slice u_slice (
                .a  (A[4*i +: 4]),
                .b  (B[4*i +: 4]),
                .ci (gc[i]),
                .s  (S[4*i +: 4]),
                .gg (gg[i]),
                .pg (pg[i])
            );
            assign gc[i+1] = gg[i] | (pg[i] & gc[i]);
        end
    endgenerate

    assign C_out = gc[NG];
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   sub_i,
    input  logic                   carry_i,
    input  logic [WORDS*WIDTH-1:0] A_i,
    input  logic [WORDS*WIDTH-1:0] B_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [WORDS*WIDTH-1:0] S_o,
    output logic                   C_o
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    output logic                   ovf_o
`endif
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    RUN  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [0:0]                    state_q;
    logic [CW-1:0]                 cnt_q;
    logic [WORDS-1:0][WIDTH-1:0]   a_q, b_q, s_q;
    logic                          cy_q, c_q, done_q;
    logic [WIDTH-1:0]              a_w, b_w, sum_w;
    logic                          co_w;

    // current word selected by the counter feeds the shared adder
    assign a_w = a_q[cnt_q];
    assign b_w = b_q[cnt_q];

    Group_carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
        .A     (a_w),
        .B     (b_w),
        .C_in  (cy_q),
        .S     (sum_w),
        .C_out (co_w)
    );

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign S_o    = s_q;
    assign C_o    = c_q;

    // sequencer: latch operands on start, then one word per cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= A_i;
                        // subtract is A + ~B + 1: invert B here, +1 via carry-in
                        b_q     <= sub_i ? ~B_i : B_i;
                        cy_q    <= sub_i ? 1'b1 : carry_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q[cnt_q] <= sum_w;
                    cy_q       <= co_w;
                    if (cnt_q == LAST) begin
                        c_q     <= co_w;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MULTIWORD_ADD_OVF_EN
    logic ovf_q;
    assign ovf_o = ovf_q;

    // signed overflow judged on the top word at the final step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && cnt_q == LAST) begin
            ovf_q <= (a_w[WIDTH-1] == b_w[WIDTH-1]) && (sum_w[WIDTH-1] != a_w[WIDTH-1]);
        end
    end
`endif
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WIDTH=16, WORDS=4).
module tb_multiword_add_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, sub_i, carry_i;
    logic [63:0] A_i, B_i;
    logic        busy_o, done_o, C_o;
    logic [63:0] S_o;
`ifdef MULTIWORD_ADD_OVF_EN
    logic        ovf_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int busy_cnt;
    logic seen;

    multiword_add_sequencer #(.WIDTH(16), .WORDS(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .sub_i   (sub_i),
        .carry_i (carry_i),
        .A_i     (A_i),
        .B_i     (B_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .S_o     (S_o),
        .C_o     (C_o)
`ifdef MULTIWORD_ADD_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge; drives start for one edge, then scrambles operands
    task automatic do_start(input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic cin);
        A_i = a; B_i = b; sub_i = sub; carry_i = cin; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        A_i = 64'hDEAD_BEEF_0BAD_F00D; B_i = 64'h1357_9BDF_2468_ACE0;
        sub_i = ~sub; carry_i = ~cin;
    endtask

    // waits for done; lat = edges after the start edge (first negedge after start = 0)
    task automatic wait_done(input int lat0, output int l, output int bcnt);
        l = lat0; bcnt = 0;
        while (!done_o && l < 20) begin
            if (busy_o) bcnt++;
            @(negedge clk_i);
            l++;
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; sub_i = 1'b0; carry_i = 1'b0;
        A_i = '0; B_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_S", S_o, 64'd0);
        check("rst_C", {63'd0, C_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // add with carry rippling through every word
        do_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("add_lat", 64'(lat), 64'd4);
        check("add_busycnt", 64'(busy_cnt), 64'd4);
        check("add_busy_at_done", {63'd0, busy_o}, 64'd0);
        check("add_S", S_o, 64'h0);
        check("add_C", {63'd0, C_o}, 64'd1);
        @(negedge clk_i);
        check("done_one_cycle", {63'd0, done_o}, 64'd0);

        // subtract with borrow, then without
        do_start(64'h5, 64'h7, 1'b1, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("sub1_S", S_o, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub1_C", {63'd0, C_o}, 64'd0);
        @(negedge clk_i);
        do_start(64'h7, 64'h5, 1'b1, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("sub2_S", S_o, 64'h2);
        check("sub2_C", {63'd0, C_o}, 64'd1);
        @(negedge clk_i);

        // carry-in crossing a word boundary
        do_start(64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1);
        wait_done(0, lat, busy_cnt);
        check("cin_S", S_o, 64'h0000_0000_0001_0000);
        check("cin_C", {63'd0, C_o}, 64'd0);
        @(negedge clk_i);

        // start while busy is ignored
        do_start(64'h1234_0000_0000_0001, 64'h1, 1'b0, 1'b0);
        check("busy_after_start", {63'd0, busy_o}, 64'd1);
        A_i = 64'h0; B_i = 64'hFFFF; sub_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(1, lat, busy_cnt);
        check("ign_lat", 64'(lat), 64'd4);
        check("ign_S", S_o, 64'h1234_0000_0000_0002);
        check("ign_C", {63'd0, C_o}, 64'd0);

        // back-to-back: start in the done cycle is accepted
        do_start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        check("b2b_done_dropped", {63'd0, done_o}, 64'd0);
        check("b2b_busy", {63'd0, busy_o}, 64'd1);
        wait_done(0, lat, busy_cnt);
        check("b2b_lat", 64'(lat), 64'd4);
        check("b2b_S", S_o, 64'h0000_0000_0000_0001);
        check("b2b_C", {63'd0, C_o}, 64'd1);
        @(negedge clk_i);

        // reset two edges into RUN aborts the operation
        do_start(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_S", S_o, 64'h0);
        check("abort_C", {63'd0, C_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);
        do_start(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_S", S_o, 64'h2222_3333_4444_5555);
        check("post_rst_C", {63'd0, C_o}, 64'd0);
        @(negedge clk_i);

`ifdef MULTIWORD_ADD_OVF_EN
        do_start(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("ovf_add_S", S_o, 64'h8000_0000_0000_0000);
        check("ovf_add_ovf", {63'd0, ovf_o}, 64'd1);
        check("ovf_add_C", {63'd0, C_o}, 64'd0);
        @(negedge clk_i);
        do_start(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("ovf_sub_S", S_o, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ovf_sub_ovf", {63'd0, ovf_o}, 64'd1);
        @(negedge clk_i);
        do_start(64'h7, 64'h5, 1'b1, 1'b0);
        wait_done(0, lat, busy_cnt);
        check("noovf_ovf", {63'd0, ovf_o}, 64'd0);
        @(negedge clk_i);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
